// File: rtl/pipeline_pkg.sv
// Constants shared by the SimplePipeline front end, control unit and pipeline registers.
package pipeline_pkg;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/instr_rom_byte.sv
// Byte-wide instruction store with a preload write port and a combinational big-endian word read.
// The read has zero latency. A write becomes visible from the next cycle, so a same-cycle read returns the old byte.
module instr_rom_byte #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              i_pre_we,
  input  logic [ADDR_W-1:0] i_pre_addr,
  input  logic [7:0]        i_pre_data,
  input  logic [ADDR_W-3:0] i_rd_word,
  output logic [31:0]       o_rd_data
);
  logic [7:0] r_mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (i_pre_we) begin
      r_mem[i_pre_addr] <= i_pre_data;
    end
  end

  // The lowest address holds the most significant byte.
  assign o_rd_data = {r_mem[{i_rd_word, 2'b00}], r_mem[{i_rd_word, 2'b01}],
                      r_mem[{i_rd_word, 2'b10}], r_mem[{i_rd_word, 2'b11}]};
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC/nPC fetch front end with a single branch delay slot; one cycle from PC to instr_out.
// Stall via le=0 freezes PC, nPC, instr_out, instr_valid and fetch_count, and ignores branch_taken.
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int          MEM_BYTES = 512,
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               le,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               pre_we,
  input  logic [ADDR_W-1:0]  pre_addr,
  input  logic [7:0]         pre_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [31:0]        pc_out,
  output logic [31:0]        npc_out,
  output logic [31:0]        fetch_count
);
  logic [31:0]        r_pc;
  logic [31:0]        r_npc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic [31:0]        r_count;
  logic [31:0]        w_word;
  logic [31:0]        w_target;

  // Only the low address bits select the word, so fetches wrap modulo MEM_BYTES.
  instr_rom_byte #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_rom (
    .clk        (clk),
    .i_pre_we   (pre_we),
    .i_pre_addr (pre_addr),
    .i_pre_data (pre_data),
    .i_rd_word  (r_pc[ADDR_W-1:2]),
    .o_rd_data  (w_word)
  );

  assign w_target = branch_target & ~32'h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC + PC_INCR;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_count <= 32'd0;
    end else if (le) begin
      r_instr <= w_word;
      r_valid <= 1'b1;
      r_pc    <= r_npc;
      r_npc   <= branch_taken ? w_target : r_npc + PC_INCR;
      r_count <= r_count + 32'd1;
    end
  end

  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc;
  assign npc_out     = r_npc;
  assign fetch_count = r_count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural fetch model checked every cycle plus literal expectations.
module tb_instruction_fetch_unit;
  localparam int MEM_BYTES = 512;

  logic        clk;
  logic        reset;
  logic        le;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [7:0]  pre_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit #(
    .MEM_BYTES (512),
    .ADDR_W    (9),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pre_we        (pre_we),
    .pre_addr      (pre_addr),
    .pre_data      (pre_data),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .npc_out       (npc_out),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: byte memory plus architectural PC/nPC state.
  logic [7:0]  m_mem [MEM_BYTES];
  logic [31:0] m_pc, m_npc, m_instr, m_count;
  logic        m_valid;
  bit          m_known = 1'b0;

  function automatic logic [31:0] model_word(input logic [31:0] pc);
    int a;
    a = int'(pc % MEM_BYTES) / 4 * 4;
    return {m_mem[a], m_mem[(a + 1) % MEM_BYTES], m_mem[(a + 2) % MEM_BYTES], m_mem[(a + 3) % MEM_BYTES]};
  endfunction

  always @(posedge clk) begin
    logic [31:0] word;
    word = model_word(m_pc);
    if (reset) begin
      m_pc = 32'h0; m_npc = 32'h4; m_instr = 32'h0; m_valid = 1'b0; m_count = 32'h0;
      m_known = 1'b1;
    end else if (le) begin
      m_instr = word;
      m_valid = 1'b1;
      m_pc    = m_npc;
      m_npc   = branch_taken ? (branch_target / 4) * 4 : m_npc + 32'd4;
      m_count = m_count + 32'd1;
    end
    if (pre_we) m_mem[pre_addr] = pre_data;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      check32("model instr_out", instr_out, m_instr);
      check32("model instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check32("model pc_out", pc_out, m_pc);
      check32("model npc_out", npc_out, m_npc);
      check32("model fetch_count", fetch_count, m_count);
    end
  end

  // One clock: drive after negedge, return 1 time unit after the posedge.
  task automatic cyc(input logic rst, input logic l, input logic bt, input logic [31:0] tgt,
                     input logic we, input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    reset = rst; le = l; branch_taken = bt; branch_target = tgt;
    pre_we = we; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic bt, input logic [31:0] tgt);
    cyc(1'b0, 1'b1, bt, tgt, 1'b0, 9'd0, 8'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'd0, 8'd0);
  endtask

  task automatic preload_word(input logic [8:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a + 9'(i), w[31 - 8*i -: 8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; le = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    pre_we = 1'b0; pre_addr = 9'd0; pre_data = 8'd0;
    preload_word(9'h000, 32'h24050000);
    preload_word(9'h004, 32'h24060001);
    preload_word(9'h008, 32'h24070002);
    preload_word(9'h040, 32'hAAAA0000);
    preload_word(9'h044, 32'h11223344);
    preload_word(9'h1FC, 32'hDEADBEEF);

    // Sequential fetch after reset
    do_reset();
    check32("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    check32("reset npc", npc_out, 32'h4);
    fetch(1'b0, 32'h0);
    check32("seq1 instr", instr_out, 32'h24050000);
    check32("seq1 pc", pc_out, 32'h4);
    fetch(1'b0, 32'h0);
    check32("seq2 instr", instr_out, 32'h24060001);
    fetch(1'b0, 32'h0);
    check32("seq3 instr", instr_out, 32'h24070002);
    check32("seq3 pc", pc_out, 32'hC);
    check32("seq3 count", fetch_count, 32'd3);

    // Branch with delay slot
    do_reset();
    fetch(1'b1, 32'h40);
    check32("br npc", npc_out, 32'h40);
    fetch(1'b0, 32'h0);
    check32("br delay slot", instr_out, 32'h24060001);
    check32("br pc", pc_out, 32'h40);
    fetch(1'b0, 32'h0);
    check32("br target instr", instr_out, 32'hAAAA0000);
    check32("br pc2", pc_out, 32'h44);

    // Stall with a branch pulse that must be ignored
    do_reset();
    fetch(1'b0, 32'h0);
    fetch(1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'd0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 9'd0, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'd0, 8'd0);
    check32("stall instr", instr_out, 32'h24060001);
    check32("stall pc", pc_out, 32'h8);
    check32("stall count", fetch_count, 32'd2);
    fetch(1'b0, 32'h0);
    check32("resume instr", instr_out, 32'h24070002);

    // Misaligned target
    do_reset();
    fetch(1'b1, 32'h43);
    check32("align npc", npc_out, 32'h40);
    fetch(1'b0, 32'h0);
    fetch(1'b0, 32'h0);
    check32("align instr", instr_out, 32'hAAAA0000);

    // Memory wrap and 32-bit PC wrap
    do_reset();
    fetch(1'b1, 32'h1FC);
    fetch(1'b0, 32'h0);
    fetch(1'b0, 32'h0);
    check32("wrap 1fc instr", instr_out, 32'hDEADBEEF);
    check32("wrap pc 200", pc_out, 32'h200);
    fetch(1'b1, 32'hFFFF_FFFC);
    check32("wrap 200 instr", instr_out, 32'h24050000);
    fetch(1'b0, 32'h0);
    check32("wrap 204 instr", instr_out, 32'h24060001);
    check32("wrap npc zero", npc_out, 32'h0);
    fetch(1'b0, 32'h0);
    check32("wrap fffffffc instr", instr_out, 32'hDEADBEEF);

    // Reset mid-run together with a preload write
    do_reset();
    fetch(1'b1, 32'h20);
    fetch(1'b0, 32'h0);
    check32("mid pc", pc_out, 32'h20);
    cyc(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 9'h000, 8'hFF);
    check32("mid rst pc", pc_out, 32'h0);
    check32("mid rst npc", npc_out, 32'h4);
    check32("mid rst valid", {31'd0, instr_valid}, 32'd0);
    check32("mid rst count", fetch_count, 32'd0);
    // Byte 1 is rewritten in the same cycle it is read: old value expected
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'h001, 8'h77);
    check32("preload kept", instr_out, 32'hFF050000);
    do_reset();
    fetch(1'b0, 32'h0);
    check32("rbw new byte", instr_out, 32'hFF770000);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the SimplePipeline: owns the PC/nPC register pair, reads a byte-addressed instruction memory, and drives the 32-bit instruction word into the pipeline's instruction input each cycle. It replaces the bench-driven constant instruction with a real fetch source. Branches use one delay slot (PC <= nPC, nPC <= target). A byte-wide preload port lets the bench or a loader fill memory before reset is released.

Parameters:
MEM_BYTES, 512, instruction memory size in bytes; power of two, at least 4.
ADDR_W, 9, memory byte-address width; equals log2(MEM_BYTES).
RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high; sampled only on posedge clk.
le  in  1  load enable; 0 = stall: PC, nPC and instr_out hold.
branch_taken  in  1  from EX/ID; when 1 with le=1, nPC loads branch_target.
branch_target  in  32  byte address of the branch destination.
pre_we  in  1  preload write strobe.
pre_addr  in  ADDR_W  preload byte address.
pre_data  in  8  preload byte.
instr_out  out  32  fetched instruction; feeds the pipeline's instruction_in.
instr_valid  out  1  instr_out holds a real fetched word.
pc_out  out  32  current PC, for debug and the bench display.
npc_out  out  32  current nPC.
fetch_count  out  32  number of fetches completed since reset.

Behaviour:
- Reset (reset=1 at posedge), which has priority over every other input:
  - PC=RESET_PC, nPC=RESET_PC+4.
  - instr_out=32'h0 (NOP), instr_valid=0, fetch_count=0.
  - Memory contents are not cleared.
  - Reset in the middle of a stall or branch discards all pending state.
- Memory reads:
  - Combinational and big-endian: word = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with a = PC[ADDR_W-1:0] and bits[1:0] forced to 00.
  - Addresses wrap modulo MEM_BYTES. The upper PC bits are ignored for the read but kept in pc_out.
- Fetch cycle (le=1, reset=0):
  - instr_out <= word at PC; instr_valid <= 1.
  - PC <= nPC.
  - nPC <= branch_taken ? {branch_target[31:2], 2'b00} : nPC+4. A misaligned target is silently aligned.
  - fetch_count <= fetch_count+1, wrapping at 2^32.
- Delay slot: the instruction at the old nPC is always fetched after a branch. There is no flush.
- Stall (le=0):
  - PC, nPC, instr_out, instr_valid and fetch_count hold.
  - branch_taken is ignored. The hazard unit must hold the branch request until le=1.
- Arithmetic: PC and nPC are 32-bit and wrap mod 2^32, so nPC=32'hFFFF_FFFC becomes 0.
- Preload:
  - On posedge with pre_we=1, mem[pre_addr] <= pre_data. Preload is allowed during reset.
  - If the byte being written is also being read in that cycle, instr_out takes the OLD byte (read before write).
- Latency: one cycle from PC to instr_out. Sequence after reset release with le=1: cycle 1 fetches RESET_PC, cycle 2 fetches RESET_PC+4.
- State: two registers (PC/nPC), with no other FSM. The bench treats instr_valid as its state: 0 from reset until the first fetch, then 1 until the next reset.

Decomposition:
- Shared package pipeline_pkg holds:
  - NOP_INSTR = 32'h0.
  - INSTR_W = 32.
  - the PC increment constant 4.
  - the RESET_PC default.
  These are the same constants the control unit and pipeline registers use.
- One natural sub-module, instr_rom_byte: the byte array, preload write port and big-endian 4-byte combinational read.
- PC/nPC sequencing stays in the top module.

Test Plan:
- Reset with le=1, memory preloaded with words 32'h24050000 at 0, 32'h24060001 at 4 and 32'h24070002 at 8 -> instr_out sequence 24050000, 24060001, 24070002; pc_out 4, 8, 12; fetch_count 1, 2, 3; instr_valid low until the first fetch.
- Branch at fetch 1 (branch_taken=1, target=32'h40, with 32'hAAAA0000 preloaded at 0x40) -> next fetches: word at 4 (delay slot), then AAAA0000; PC sequence 0, 4, 0x40, 0x44.
- le=0 for 3 cycles after the second fetch, with branch_taken pulsed during the stall -> instr_out, pc_out and fetch_count frozen; branch ignored; fetching resumes at PC=8.
- branch_target=32'h43 -> nPC=32'h40.
- Address wrap: PC=0x1FC -> next fetch reads byte address 0; PC=32'h0000_0200 reads the same word as PC=0.
- Reset asserted mid-run (PC=0x20) together with pre_we writing 8'hFF at 0 -> PC=0, nPC=4, instr_valid=0, fetch_count=0; the first fetch after release returns FF050000, showing preload during reset is kept.
